// File: rtl/muxnto1_rr.sv
// muxnto1_rr: registered N-to-1 channel multiplexer with a ready/valid
// handshake on every channel and on the output. Selection is either a fixed
// channel index or round-robin arbitration over the valid channels.
module muxnto1_rr #(
  parameter int unsigned SELW  = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        mode_i,
  input  logic [SELW-1:0]             select_i,
  input  logic [(2**SELW)-1:0]        in_valid_i,
  input  logic [(2**SELW)*WIDTH-1:0]  in_data_i,
  output logic [(2**SELW)-1:0]        in_ready_o,
  output logic                        out_valid_o,
  output logic [WIDTH-1:0]            out_data_o,
  output logic [SELW-1:0]             out_chan_o,
  input  logic                        out_ready_i
);

  localparam int unsigned N = 2**SELW;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  mode_e             mode;
  logic              load;
  logic              grant;
  logic [SELW-1:0]   gnt_idx;
  logic [SELW-1:0]   scan_idx;
  logic [WIDTH-1:0]  chan_data [N];

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q,  out_data_d;
  logic [SELW-1:0]   out_chan_q,  out_chan_d;
  logic [SELW-1:0]   ptr_q,       ptr_d;

  assign mode = mode_e'(mode_i);

  // Unpack the flat data bus into one word per channel.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      chan_data[i] = in_data_i[i*WIDTH +: WIDTH];
    end
  end

  // The output register may take a new word when empty or being drained.
  always_comb begin
    load = !out_valid_q || out_ready_i;
  end

  // Arbitration: fixed index, or first valid channel scanning upward from ptr
  // with wrap-around. The scan keeps the first hit, so later hits are ignored.
  always_comb begin
    grant    = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    if (mode == MODE_FIXED) begin
      if (in_valid_i[select_i]) begin
        grant   = 1'b1;
        gnt_idx = select_i;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        scan_idx = ptr_q + SELW'(k);
        if (!grant && in_valid_i[scan_idx]) begin
          grant   = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
  end

  // Accept strobe: one-hot on the granted channel only when the word is taken.
  always_comb begin
    in_ready_o = '0;
    if (rst_ni && load && grant) begin
      in_ready_o[gnt_idx] = 1'b1;
    end
  end

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (grant) begin
        out_valid_d = 1'b1;
        out_data_d  = chan_data[gnt_idx];
        out_chan_d  = gnt_idx;
        if (mode == MODE_RR) begin
          ptr_d = gnt_idx + SELW'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_chan_o  = out_chan_q;

endmodule

// File: tb/tb_muxnto1_rr.sv
// tb_muxnto1_rr: directed scenarios followed by random traffic, each cycle
// compared against a behavioural model of the multiplexer.
module tb_muxnto1_rr;

  localparam int SELW  = 2;
  localparam int WIDTH = 8;
  localparam int N     = 2**SELW;

  logic                 clk;
  logic                 rst_n;
  logic                 mode;
  logic [SELW-1:0]      select;
  logic [N-1:0]         in_valid;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_chan;
  logic                 out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int m_valid = 0;
  int m_data  = 0;
  int m_chan  = 0;
  int m_ptr   = 0;

  muxnto1_rr #(.SELW(SELW), .WIDTH(WIDTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mode_i      (mode),
    .select_i    (select),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_chan_o  (out_chan),
    .out_ready_i (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which channel the model would pick from the current inputs.
  task automatic model_pick(output int g, output int ch);
    g  = 0;
    ch = 0;
    if (mode == 1'b0) begin
      if (in_valid[select]) begin
        g  = 1;
        ch = int'(select);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g == 0 && in_valid[c]) begin
          g  = 1;
          ch = c;
        end
      end
    end
  endtask

  // One clock cycle: check in_ready mid-cycle, advance the model at the edge,
  // then check the registered outputs just after it.
  task automatic cycle(input string tag);
    int g, ch, ld;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    model_pick(g, ch);
    ld = (m_valid == 0 || out_ready) ? 1 : 0;
    exp_ready = '0;
    if (rst_n && ld != 0 && g != 0) exp_ready = N'(1) << ch;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_chan = 0; m_ptr = 0;
    end else if (ld != 0) begin
      if (g != 0) begin
        m_valid = 1;
        m_data  = int'((in_data >> (ch*WIDTH)) & 32'hFF);
        m_chan  = ch;
        if (mode) m_ptr = (ch + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, "_out_data"},  32'(out_data),  32'(m_data));
    chk({tag, "_out_chan"},  32'(out_chan),  32'(m_chan));
  endtask

  task automatic set_all_data(input logic [WIDTH-1:0] base);
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = base + WIDTH'(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; select = '0; in_valid = '1; out_ready = 1'b1;
    set_all_data(8'hA0);

    // Reset with valid inputs present: outputs zero, in_ready zero.
    cycle("rst0");
    cycle("rst1");
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);

    // Fixed select 2.
    rst_n = 1'b1; mode = 1'b0; select = 2'd2; in_valid = 4'b1111;
    #1 chk("fix_ready", 32'(in_ready), 32'h4);
    cycle("fix");
    chk("fix_data", 32'(out_data), 32'hA2);
    chk("fix_chan", 32'(out_chan), 32'd2);

    // Round-robin from reset with all valid: 0,1,2,3,0.
    do_reset();
    mode = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle("rr_seq");
      chk("rr_seq_chan", 32'(out_chan), 32'(i % N));
    end

    // Wrap scan: ptr = 3, valid 0110 -> channel 1, then channel 2.
    do_reset();
    in_valid = 4'b1111;
    repeat (3) cycle("rr_pre");
    in_valid = 4'b0110;
    cycle("rr_wrap");
    chk("rr_wrap_chan", 32'(out_chan), 32'd1);
    in_valid = 4'b1111;
    cycle("rr_after");
    chk("rr_after_chan", 32'(out_chan), 32'd2);

    // Back-pressure holding 8'h55.
    mode = 1'b0; select = 2'd0; in_valid = 4'b0001;
    in_data[0 +: WIDTH] = 8'h55;
    cycle("bp_load");
    chk("bp_load_data", 32'(out_data), 32'h55);
    out_ready = 1'b0; in_valid = 4'b1111; set_all_data(8'hC0);
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold");
      chk("bp_hold_data", 32'(out_data), 32'h55);
    end
    out_ready = 1'b1;
    cycle("bp_release");
    chk("bp_release_data", 32'(out_data), 32'hC0);

    // Reset mid-stream, then round-robin picks channel 3 and ptr goes to 0.
    mode = 1'b1;
    cycle("mid_pre");
    rst_n = 1'b0;
    cycle("mid_rst");
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data",  32'(out_data),  32'd0);
    rst_n = 1'b1; in_valid = 4'b1000;
    cycle("mid_g3");
    chk("mid_g3_chan", 32'(out_chan), 32'd3);
    in_valid = 4'b1111;
    cycle("mid_next");
    chk("mid_next_chan", 32'(out_chan), 32'd0);

    // No valid inputs in both modes.
    in_valid = '0;
    mode = 1'b1; cycle("idle_rr");
    chk("idle_rr_valid", 32'(out_valid), 32'd0);
    mode = 1'b0; cycle("idle_fix");
    chk("idle_fix_valid", 32'(out_valid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 31) != 0);
      mode      = 1'($urandom);
      select    = SELW'($urandom);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) in_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
